// File: rtl/pila_retorno.sv
// pila_retorno: return-address LIFO fed by the control unit's wesp/push/pop strobes; optional PILA_ERR_STICKY_EN.
// Latency: d_out is combinational from the stored top entry; sp updates on clk; ovf/unf appear the cycle after the offending edge.
// Backpressure: none; a push while full or a pop while empty is dropped and flagged (pulse, or sticky until reset with PILA_ERR_STICKY_EN).
module pila_retorno #(
  parameter int AW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wesp,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              d_in,
  output logic [AW-1:0]              d_out,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       ovf,
  output logic                       unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] sp;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_repl;
  logic          ovf_ev;
  logic          unf_ev;

  // Status comes straight from the registered pointer, never from the strobes.
  assign empty     = (sp == '0);
  assign full      = (sp == CW'(DEPTH));
  assign depth_cnt = sp;

  // Decode the effective operation; the strobes only matter while wesp is high.
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_repl = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    wr_idx  = IW'(sp);
    top_idx = IW'(sp - CW'(1));
    if (wesp) begin
      case ({push, pop})
        2'b10: begin
          if (full) ovf_ev  = 1'b1;
          else      do_push = 1'b1;
        end
        2'b01: begin
          if (empty) unf_ev = 1'b1;
          else       do_pop = 1'b1;
        end
        2'b11: begin
          // Call and return in the same cycle replaces the top; on an empty stack it is just a call.
          if (empty) do_push = 1'b1;
          else       do_repl = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Top of stack goes to the PC mux with zero latency; masked to 0 so stale storage never leaks out.
  always_comb begin
    d_out = '0;
    if (!empty) d_out = mem[top_idx];
  end

  // Stack pointer: saturates at 0 and DEPTH, no circular wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        sp <= '0;
    else if (do_push) sp <= sp + CW'(1);
    else if (do_pop)  sp <= sp - CW'(1);
  end

  // Entry storage needs no reset: contents are only visible through the empty mask.
  always_ff @(posedge clk) begin
    if (do_push)      mem[wr_idx]  <= d_in;
    else if (do_repl) mem[top_idx] <= d_in;
  end

  // Misuse flags, registered one cycle after the offending edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
`ifdef PILA_ERR_STICKY_EN
      ovf <= ovf | ovf_ev;
      unf <= unf | unf_ev;
`else
      ovf <= ovf_ev;
      unf <= unf_ev;
`endif
    end
  end

endmodule

// File: tb/tb_pila_retorno.sv
// Directed bench for pila_retorno (DEPTH=4, AW=10) with a reference stack model.
// Expected outputs are queued when each step is driven and compared after the clock edge.
module tb_pila_retorno;

  logic       clk = 1'b0;
  logic       reset;
  logic       wesp;
  logic       push;
  logic       pop;
  logic [9:0] d_in;
  logic [9:0] d_out;
  logic       empty;
  logic       full;
  logic [2:0] depth_cnt;
  logic       ovf;
  logic       unf;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  typedef struct {
    logic [9:0] dout;
    int         depth;
    logic       emp;
    logic       ful;
    logic       ov;
    logic       un;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] stk[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  pila_retorno #(.AW(10), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wesp      (wesp),
    .push      (push),
    .pop       (pop),
    .d_in      (d_in),
    .d_out     (d_out),
    .empty     (empty),
    .full      (full),
    .depth_cnt (depth_cnt),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] m_top();
    if (stk.size() == 0) return 10'h000;
    return stk[stk.size()-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/d_out"},     32'(d_out),     32'h0);
    chk({tag, "/depth_cnt"}, 32'(depth_cnt), 32'h0);
    chk({tag, "/empty"},     32'(empty),     32'h1);
    chk({tag, "/full"},      32'(full),      32'h0);
    chk({tag, "/ovf"},       32'(ovf),       32'h0);
    chk({tag, "/unf"},       32'(unf),       32'h0);
  endtask

  // One clocked operation: model predicts, DUT is compared after the edge.
  task automatic step(input logic w, input logic p, input logic q, input logic [9:0] d, input string tag);
    exp_t e;
    logic ov_ev;
    logic un_ev;
    wesp = w; push = p; pop = q; d_in = d;
    #1;
    chk({tag, "/pre_dout"}, 32'(d_out), 32'(m_top()));
    ov_ev = 1'b0;
    un_ev = 1'b0;
    if (w) begin
      if (p && !q) begin
        if (stk.size() < 4) stk.push_back(d);
        else                ov_ev = 1'b1;
      end else if (q && !p) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else                un_ev = 1'b1;
      end else if (p && q) begin
        if (stk.size() > 0) stk[stk.size()-1] = d;
        else                stk.push_back(d);
      end
    end
`ifdef PILA_ERR_STICKY_EN
    m_ovf = m_ovf | ov_ev;
    m_unf = m_unf | un_ev;
`else
    m_ovf = ov_ev;
    m_unf = un_ev;
`endif
    e.dout  = m_top();
    e.depth = stk.size();
    e.emp   = (stk.size() == 0);
    e.ful   = (stk.size() == 4);
    e.ov    = m_ovf;
    e.un    = m_unf;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "/d_out"},     32'(d_out),     32'(e.dout));
    chk({tag, "/depth_cnt"}, 32'(depth_cnt), 32'(e.depth));
    chk({tag, "/empty"},     32'(empty),     32'(e.emp));
    chk({tag, "/full"},      32'(full),      32'(e.ful));
    chk({tag, "/ovf"},       32'(ovf),       32'(e.ov));
    chk({tag, "/unf"},       32'(unf),       32'(e.un));
    wesp = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  // Reset asserted between edges must clear outputs without any clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wesp = 1'b0; push = 1'b0; pop = 1'b0; d_in = 10'h000;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;

    step(1'b0, 1'b0, 1'b0, 10'h000, "idle");
    step(1'b1, 1'b1, 1'b0, 10'h011, "push_011");
    step(1'b1, 1'b1, 1'b0, 10'h022, "push_022");
    step(1'b1, 1'b1, 1'b0, 10'h033, "push_033");
    step(1'b1, 1'b0, 1'b1, 10'h000, "pop_033");
    step(1'b1, 1'b1, 1'b0, 10'h044, "push_044");
    async_reset("mid_rst");

    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, 10'(i), "fill");
    step(1'b1, 1'b1, 1'b0, 10'h3FF, "ovf_push");
    step(1'b0, 1'b0, 1'b0, 10'h000, "ovf_after");
    step(1'b1, 1'b0, 1'b1, 10'h000, "pop_from_full");
    async_reset("rst_ovf");

    step(1'b1, 1'b0, 1'b1, 10'h000, "unf_pop");
    step(1'b1, 1'b1, 1'b0, 10'h0AA, "push_0aa");
    step(1'b1, 1'b0, 1'b1, 10'h000, "pop_0aa");
    step(1'b1, 1'b1, 1'b1, 10'h0CC, "pp_empty");
    async_reset("rst_repl");

    step(1'b1, 1'b1, 1'b0, 10'h010, "push_010");
    step(1'b1, 1'b1, 1'b0, 10'h020, "push_020");
    step(1'b1, 1'b1, 1'b1, 10'h155, "repl_155");
    step(1'b1, 1'b0, 1'b1, 10'h000, "pop_155");

    step(1'b0, 1'b1, 1'b0, 10'h3FF, "nowe_push");
    step(1'b0, 1'b0, 1'b1, 10'h3FF, "nowe_pop");
    step(1'b0, 1'b1, 1'b1, 10'h3FF, "nowe_both");
    step(1'b0, 1'b1, 1'b0, 10'h2AA, "nowe_push2");
    step(1'b0, 1'b0, 1'b1, 10'h155, "nowe_pop2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
